cntr_updown_n: RTL and testbench

//  Parametrised up/down counter with synchronous load, programmable step and

---
 rtl/cntr_pkg.sv | 9 +
 rtl/cntr_updown_n_register_ar.sv | 14 +
 rtl/cntr_updown_n.sv | 54 +++++
 tb/tb_cntr_updown_n.sv | 126 ++++++++++++
 4 files changed

// File: rtl/cntr_pkg.sv
// cntr_pkg: state encodings shared by the up/down counter RTL and its bench.
package cntr_pkg;
    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] IDLE = 3'b000;
    localparam logic [STATE_W-1:0] LOAD = 3'b001;
    localparam logic [STATE_W-1:0] INC  = 3'b010;
    localparam logic [STATE_W-1:0] DEC  = 3'b011;
    localparam logic [STATE_W-1:0] HOLD = 3'b100;
endpackage

// File: rtl/cntr_updown_n_register_ar.sv
// cntr_updown_n_register_ar: W-bit D register with asynchronous active-high reset to zero.
module cntr_updown_n_register_ar #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= '0;
        else       q <= d;
    end
endmodule

// File: rtl/cntr_updown_n.sv
// cntr_updown_n: up/down counter with load, programmable step and wrap/saturate overflow.
module cntr_updown_n
    import cntr_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int STEP_W   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               inc,
    input  logic               dec,
    input  logic [STEP_W-1:0]  step,
    input  logic [WIDTH-1:0]   d_in,
    output logic [WIDTH-1:0]   d_out,
    output logic [STATE_W-1:0] o_state,
    output logic               o_max,
    output logic               o_min,
    output logic               o_ovf
);
    logic [STATE_W-1:0] state, nxt;
    logic [WIDTH:0]     s, up, dn;
    logic               up_ovf, dn_ovf, ovf_n;
    logic [WIDTH-1:0]   cnt_n;
    logic               not_min;
    always_comb begin
        nxt = load ? LOAD : (inc & dec) ? HOLD : inc ? INC : dec ? DEC : IDLE;
    end
    cntr_updown_n_register_ar #(.W(STATE_W)) u_state (
        .clk(clk), .reset(reset), .d(nxt), .q(state)
    );
    // Extra top bit captures carry-out (INC) or borrow (DEC).
    always_comb begin
        s      = (step == '0) ? (WIDTH+1)'(1) : (WIDTH+1)'(step);
        up     = {1'b0, d_out} + s;
        dn     = {1'b0, d_out} - s;
        up_ovf = (nxt == INC) & up[WIDTH];
        dn_ovf = (nxt == DEC) & dn[WIDTH];
        ovf_n  = up_ovf | dn_ovf;
        cnt_n  = (nxt == LOAD) ? d_in :
                 (nxt == INC)  ? ((up_ovf && SATURATE) ? '1 : up[WIDTH-1:0]) :
                 (nxt == DEC)  ? ((dn_ovf && SATURATE) ? '0 : dn[WIDTH-1:0]) :
                 d_out;
    end
    // The min flag is stored inverted so the zero-reset register yields o_min=1.
    cntr_updown_n_register_ar #(.W(WIDTH+3)) u_cnt (
        .clk(clk), .reset(reset),
        .d({cnt_n, &cnt_n, |cnt_n, ovf_n}),
        .q({d_out, o_max, not_min, o_ovf})
    );
    assign o_min   = ~not_min;
    assign o_state = state;
endmodule

// File: tb/tb_cntr_updown_n.sv
// tb_cntr_updown_n: directed checks of a wrapping and a saturating counter driven in parallel.
module tb_cntr_updown_n;
    import cntr_pkg::*;
    logic       clk = 0, reset = 0, load = 0, inc = 0, dec = 0;
    logic [3:0] step = 0;
    logic [7:0] d_in = 0;
    logic [7:0] w_out, s_out;
    logic [2:0] w_st, s_st;
    logic       w_max, w_min, w_ovf, s_max, s_min, s_ovf;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    cntr_updown_n #(.WIDTH(8), .STEP_W(4), .SATURATE(1'b0)) dut_w (
        .clk(clk), .reset(reset), .load(load), .inc(inc), .dec(dec), .step(step), .d_in(d_in),
        .d_out(w_out), .o_state(w_st), .o_max(w_max), .o_min(w_min), .o_ovf(w_ovf)
    );
    cntr_updown_n #(.WIDTH(8), .STEP_W(4), .SATURATE(1'b1)) dut_s (
        .clk(clk), .reset(reset), .load(load), .inc(inc), .dec(dec), .step(step), .d_in(d_in),
        .d_out(s_out), .o_state(s_st), .o_max(s_max), .o_min(s_min), .o_ovf(s_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic l, input logic i, input logic d, input logic [3:0] st, input logic [7:0] v);
        load = l; inc = i; dec = d; step = st; d_in = v;
        @(posedge clk);
        #1;
        load = 0; inc = 0; dec = 0;
    endtask

    initial begin
        reset = 1;
        #12;
        chk("rst_out", w_out, 8'h00);
        chk("rst_state", w_st, IDLE);
        chk("rst_min", w_min, 1'b1);
        chk("rst_max", w_max, 1'b0);
        chk("rst_ovf", w_ovf, 1'b0);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 8'h37);
        chk("pre_rst_out", w_out, 8'h37);
        @(negedge clk);
        reset = 1;
        #1;
        chk("async_rst_out", w_out, 8'h00);
        chk("async_rst_min", w_min, 1'b1);
        @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 8'hA5);
        chk("ld_out", w_out, 8'hA5);
        chk("ld_state", w_st, LOAD);
        cyc(0, 1, 0, 3, 8'h00);
        chk("inc1_out", w_out, 8'hA8);
        chk("inc1_state", w_st, INC);
        cyc(0, 1, 0, 3, 8'h00);
        chk("inc2_out", w_out, 8'hAB);
        chk("inc2_state", w_st, INC);
        chk("inc2_ovf", w_ovf, 1'b0);
        cyc(1, 0, 0, 0, 8'hFE);
        cyc(0, 1, 0, 3, 8'h00);
        chk("wrap_up_out", w_out, 8'h01);
        chk("wrap_up_ovf", w_ovf, 1'b1);
        cyc(0, 0, 0, 0, 8'h00);
        chk("ovf_pulse_end", w_ovf, 1'b0);
        chk("idle_hold", w_out, 8'h01);
        chk("idle_state", w_st, IDLE);
        cyc(1, 0, 0, 0, 8'h01);
        chk("ld_no_ovf", w_ovf, 1'b0);
        cyc(0, 0, 1, 2, 8'h00);
        chk("wrap_dn_out", w_out, 8'hFF);
        chk("wrap_dn_ovf", w_ovf, 1'b1);
        chk("wrap_dn_max", w_max, 1'b1);
        chk("wrap_dn_state", w_st, DEC);
        chk("sat_dn_out", s_out, 8'h00);
        chk("sat_dn_ovf", s_ovf, 1'b1);
        chk("sat_dn_min", s_min, 1'b1);
        cyc(1, 0, 0, 0, 8'hFD);
        cyc(0, 1, 0, 5, 8'h00);
        chk("sat_up_out", s_out, 8'hFF);
        chk("sat_up_ovf", s_ovf, 1'b1);
        chk("sat_up_max", s_max, 1'b1);
        chk("wrap_fd_out", w_out, 8'h02);
        cyc(0, 1, 0, 5, 8'h00);
        chk("sat_up2_out", s_out, 8'hFF);
        chk("sat_up2_ovf", s_ovf, 1'b1);
        cyc(0, 0, 1, 0, 8'h00);
        chk("sat_step0_out", s_out, 8'hFE);
        chk("sat_step0_ovf", s_ovf, 1'b0);
        chk("sat_step0_max", s_max, 1'b0);
        cyc(1, 1, 1, 2, 8'h10);
        chk("all_out", w_out, 8'h10);
        chk("all_state", w_st, LOAD);
        cyc(0, 1, 1, 2, 8'h00);
        chk("hold_out", w_out, 8'h10);
        chk("hold_state", w_st, HOLD);
        cyc(0, 0, 0, 0, 8'h00);
        chk("idle2_out", w_out, 8'h10);
        chk("idle2_state", w_st, IDLE);
        cyc(1, 0, 0, 0, 8'h05);
        chk("pre_exact_min", w_min, 1'b0);
        cyc(0, 0, 1, 5, 8'h00);
        chk("exact_out", w_out, 8'h00);
        chk("exact_min", w_min, 1'b1);
        chk("exact_ovf", w_ovf, 1'b0);
        chk("exact_sat_ovf", s_ovf, 1'b0);
        cyc(1, 0, 0, 0, 8'hF0);
        cyc(0, 1, 0, 15, 8'h00);
        chk("exact_max_out", w_out, 8'hFF);
        chk("exact_max_ovf", w_ovf, 1'b0);
        chk("exact_max_flag", w_max, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
